mem_port_arbiter: RTL and testbench

- Shares the core's single 24-bit address / 16-bit data memory port between two requesters: A (core, higher tie priority out of reset) and B (DMA/IO engine).
- Registered ownership FSM with round-robin hand-off, a bounded hold time and a lock override.
- Sits between the requesters and the memory bank. Memory read data is synchronous: valid one cycle after the address is presented.

---
 rtl/mem_port_arbiter.sv | 240 ++++++++++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 390 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// mem_port_arbiter
//
// Shares one synchronous-read memory port between two requesters:
//   A - the core (wins the very first tie after reset)
//   B - the DMA / IO engine
//
// Ownership is held in a registered three-state FSM (IDLE, OWN_A, OWN_B).
// An owner keeps the port while it requests. If the other side is waiting
// and the owner is not locked, the owner is handed off after MAX_HOLD
// accepted cycles. A lock stops pre-emption but never stops a voluntary
// release. Read data returns one cycle after acceptance. It is steered back
// to whichever requester issued the read, even across a hand-off.
//
// Optional feature (compile-time macro ARB_WAIT_CNT_EN):
//   adds a_wait_cnt / b_wait_cnt, 16-bit saturating counts of the cycles
//   each requester spent requesting without being granted.
//
// Parameters:
//   ADDR_W   memory address width
//   DATA_W   memory data width
//   MAX_HOLD accepted cycles an unlocked owner keeps the port while the
//            other requester waits (>= 1)
//
// Ports:
//   clk, rst_n                 clock (rising edge), async active-low reset
//   a_req/a_lock/a_addr/
//   a_wdata/a_we               requester A access request
//   a_gnt                      A access accepted this cycle
//   a_rdata/a_rvalid           read return to A
//   b_*                        same set for requester B
//   mem_addr/mem_wdata/mem_we  memory command
//   mem_rdata                  memory read data (valid the cycle after addr)
//   a_wait_cnt/b_wait_cnt      wait counters (ARB_WAIT_CNT_EN only)
// ---------------------------------------------------------------------------
module mem_port_arbiter #(
  parameter int ADDR_W   = 24,
  parameter int DATA_W   = 16,
  parameter int MAX_HOLD = 8
) (
  input  logic              clk,
  input  logic              rst_n,

  input  logic              a_req,
  input  logic              a_lock,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_wdata,
  input  logic              a_we,
  output logic              a_gnt,
  output logic [DATA_W-1:0] a_rdata,
  output logic              a_rvalid,

  input  logic              b_req,
  input  logic              b_lock,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] b_wdata,
  input  logic              b_we,
  output logic              b_gnt,
  output logic [DATA_W-1:0] b_rdata,
  output logic              b_rvalid,

  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we,
`ifdef ARB_WAIT_CNT_EN
  output logic [15:0]       a_wait_cnt,
  output logic [15:0]       b_wait_cnt,
`endif
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int HOLD_W = $clog2(MAX_HOLD) + 1;
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);
  localparam logic [HOLD_W-1:0] HOLD_ONE  = HOLD_W'(1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    OWN_A = 2'd1,
    OWN_B = 2'd2
  } state_e;

  state_e            state_q;
  // Last owner served: 1 = B, 0 = A. It breaks ties from IDLE.
  logic              last_b_q;
  logic [HOLD_W-1:0] hold_q;
  logic              rsel_a_q;
  logic              rsel_b_q;
  logic              rsel_a_d;
  logic              rsel_b_d;

  // Acceptance is combinational inside the owned state. Only the ownership
  // itself is registered.
  assign a_gnt = (state_q == OWN_A) && a_req;
  assign b_gnt = (state_q == OWN_B) && b_req;

  // A read is outstanding for whoever was granted a non-write this cycle.
  assign rsel_a_d = a_gnt && !a_we;
  assign rsel_b_d = b_gnt && !b_we;

  // Both requesters see the raw memory data. Only rvalid says whose it is.
  assign a_rdata  = mem_rdata;
  assign b_rdata  = mem_rdata;
  assign a_rvalid = rsel_a_q;
  assign b_rvalid = rsel_b_q;

  // Port mux: the owner drives address and data even while idle-requesting.
  // A write only reaches memory on an accepted cycle.
  always_comb begin
    mem_addr  = '0;
    mem_wdata = '0;
    mem_we    = 1'b0;
    case (state_q)
      OWN_A: begin
        mem_addr  = a_addr;
        mem_wdata = a_wdata;
        mem_we    = a_we && a_gnt;
      end
      OWN_B: begin
        mem_addr  = b_addr;
        mem_wdata = b_wdata;
        mem_we    = b_we && b_gnt;
      end
      default: begin
        mem_addr  = '0;
        mem_wdata = '0;
        mem_we    = 1'b0;
      end
    endcase
  end

  // Ownership FSM with last-served tracking and the hold counter.
  // hold_q counts accepted cycles while the other side waits. It saturates
  // at MAX_HOLD-1, which is the cycle on which an unlocked owner is handed
  // off with no dead cycle in between. The counter is zero on every entry
  // to a new state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      last_b_q <= 1'b1;
      hold_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          hold_q <= '0;
          if (a_req && (!b_req || last_b_q)) begin
            state_q <= OWN_A;
          end else if (b_req) begin
            state_q <= OWN_B;
          end
        end

        OWN_A: begin
          if (!a_req) begin
            last_b_q <= 1'b0;
            hold_q   <= '0;
            state_q  <= b_req ? OWN_B : IDLE;
          end else if (b_req && !a_lock && (hold_q == HOLD_LAST)) begin
            last_b_q <= 1'b0;
            hold_q   <= '0;
            state_q  <= OWN_B;
          end else if (b_req) begin
            if (hold_q != HOLD_LAST) begin
              hold_q <= hold_q + HOLD_ONE;
            end
          end else begin
            hold_q <= '0;
          end
        end

        OWN_B: begin
          if (!b_req) begin
            last_b_q <= 1'b1;
            hold_q   <= '0;
            state_q  <= a_req ? OWN_A : IDLE;
          end else if (a_req && !b_lock && (hold_q == HOLD_LAST)) begin
            last_b_q <= 1'b1;
            hold_q   <= '0;
            state_q  <= OWN_A;
          end else if (a_req) begin
            if (hold_q != HOLD_LAST) begin
              hold_q <= hold_q + HOLD_ONE;
            end
          end else begin
            hold_q <= '0;
          end
        end

        default: begin
          state_q <= IDLE;
          hold_q  <= '0;
        end
      endcase
    end
  end

  // Read-return flags. An async reset discards any read in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsel_a_q <= 1'b0;
      rsel_b_q <= 1'b0;
    end else begin
      rsel_a_q <= rsel_a_d;
      rsel_b_q <= rsel_b_d;
    end
  end

`ifdef ARB_WAIT_CNT_EN
  logic [15:0] a_wait_q;
  logic [15:0] b_wait_q;
  logic [15:0] a_wait_d;
  logic [15:0] b_wait_d;

  // Saturating wait counters: one tick per cycle spent requesting without a
  // grant.
  always_comb begin
    a_wait_d = a_wait_q;
    b_wait_d = b_wait_q;
    if (a_req && !a_gnt && (a_wait_q != 16'hFFFF)) begin
      a_wait_d = a_wait_q + 16'd1;
    end
    if (b_req && !b_gnt && (b_wait_q != 16'hFFFF)) begin
      b_wait_d = b_wait_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_wait_q <= 16'd0;
      b_wait_q <= 16'd0;
    end else begin
      a_wait_q <= a_wait_d;
      b_wait_q <= b_wait_d;
    end
  end

  assign a_wait_cnt = a_wait_q;
  assign b_wait_cnt = b_wait_q;
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mem_port_arbiter
//
// Drives the arbiter with directed scenarios and then random traffic. A
// small synchronous memory model in the bench answers the DUT's memory port.
// A behavioural reference tracks the owner, the count of grants made while
// the other side waits, outstanding reads and memory contents. One compare
// process checks every DUT output against that reference on every negedge.
// The directed scenarios also check literal values.
// ---------------------------------------------------------------------------
module tb_mem_port_arbiter;

  localparam int MAX_HOLD = 8;

  logic        clk;
  logic        rst_n;
  logic        aReq, aLock, aWe, bReq, bLock, bWe;
  logic [23:0] aAddr, bAddr;
  logic [15:0] aWdata, bWdata;
  logic        aGnt, aRvalid, bGnt, bRvalid;
  logic [15:0] aRdata, bRdata;
  logic [23:0] memAddr;
  logic [15:0] memWdata;
  logic        memWe;
  logic [15:0] memRdata;
`ifdef ARB_WAIT_CNT_EN
  logic [15:0] aWaitCnt, bWaitCnt;
`endif

  int errors = 0;
  int checks = 0;

  mem_port_arbiter #(
    .ADDR_W(24),
    .DATA_W(16),
    .MAX_HOLD(MAX_HOLD)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .a_req(aReq),
    .a_lock(aLock),
    .a_addr(aAddr),
    .a_wdata(aWdata),
    .a_we(aWe),
    .a_gnt(aGnt),
    .a_rdata(aRdata),
    .a_rvalid(aRvalid),
    .b_req(bReq),
    .b_lock(bLock),
    .b_addr(bAddr),
    .b_wdata(bWdata),
    .b_we(bWe),
    .b_gnt(bGnt),
    .b_rdata(bRdata),
    .b_rvalid(bRvalid),
    .mem_addr(memAddr),
    .mem_wdata(memWdata),
    .mem_we(memWe),
`ifdef ARB_WAIT_CNT_EN
    .a_wait_cnt(aWaitCnt),
    .b_wait_cnt(bWaitCnt),
`endif
    .mem_rdata(memRdata)
  );

  // Free-running 10-time-unit clock. Rising edges fall at 5, 15, 25, ...
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Bench memory: 64 words indexed by the low address bits. It is filled
  // with 16'h1000+index on the first edge. Writes land on the clock edge.
  // Read data appears the cycle after the address.
  logic [15:0] devMem [64];
  logic        devInit = 1'b0;
  always @(posedge clk) begin
    if (!devInit) begin
      for (int i = 0; i < 64; i++) devMem[i] <= 16'h1000 + 16'(i);
      devInit <= 1'b1;
    end else begin
      if (memWe) devMem[memAddr[5:0]] <= memWdata;
      memRdata <= devMem[memAddr[5:0]];
    end
  end

  // One comparison: counts it and reports a mismatch on a single line.
  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual,
               expected, $time);
    end
  endtask

  // Reference model state. The owner is 0 (none), 1 (A) or 2 (B).
  // streak counts the owner's accepted cycles since the other side
  // started waiting.
  int          owner;
  logic        lastB;
  int          streak;
  logic        pendA, pendB;
  logic [15:0] pendAData, pendBData;
  logic [15:0] modelMem [64];
  logic        modelInit = 1'b0;
  logic [31:0] expAGnt, expBGnt, expWe, expAddr, expWdata;
`ifdef ARB_WAIT_CNT_EN
  logic [15:0] waitA, waitB;
`endif

  // Compare process. At each negedge, with inputs stable, it works out what
  // the outputs must be for this cycle and compares. It then advances the
  // model past the coming rising edge. Reset edges happen only just after a
  // rising edge, so the model never has to guess how a release and a clock
  // edge are ordered.
  always @(negedge clk) begin
    if (!modelInit) begin
      for (int i = 0; i < 64; i++) modelMem[i] = 16'h1000 + 16'(i);
      modelInit = 1'b1;
    end
    if (!rst_n) begin
      owner  = 0;
      lastB  = 1'b1;
      streak = 0;
      pendA  = 1'b0;
      pendB  = 1'b0;
`ifdef ARB_WAIT_CNT_EN
      waitA = 16'd0;
      waitB = 16'd0;
      checkOutput("rstAWait", 32'(aWaitCnt), 32'd0);
      checkOutput("rstBWait", 32'(bWaitCnt), 32'd0);
`endif
      checkOutput("rstAGnt", 32'(aGnt), 32'd0);
      checkOutput("rstBGnt", 32'(bGnt), 32'd0);
      checkOutput("rstARvalid", 32'(aRvalid), 32'd0);
      checkOutput("rstBRvalid", 32'(bRvalid), 32'd0);
      checkOutput("rstMemWe", 32'(memWe), 32'd0);
      checkOutput("rstMemAddr", 32'(memAddr), 32'd0);
      checkOutput("rstMemWdata", 32'(memWdata), 32'd0);
    end else begin
      expAGnt  = 32'((owner == 1) && aReq);
      expBGnt  = 32'((owner == 2) && bReq);
      expAddr  = (owner == 1) ? 32'(aAddr) : (owner == 2) ? 32'(bAddr) : 32'd0;
      expWdata = (owner == 1) ? 32'(aWdata) : (owner == 2) ? 32'(bWdata) : 32'd0;
      expWe    = 32'(((owner == 1) && aReq && aWe) || ((owner == 2) && bReq && bWe));
      checkOutput("aGnt", 32'(aGnt), expAGnt);
      checkOutput("bGnt", 32'(bGnt), expBGnt);
      checkOutput("memWe", 32'(memWe), expWe);
      checkOutput("memAddr", 32'(memAddr), expAddr);
      checkOutput("memWdata", 32'(memWdata), expWdata);
      checkOutput("aRvalid", 32'(aRvalid), 32'(pendA));
      checkOutput("bRvalid", 32'(bRvalid), 32'(pendB));
      if (pendA) checkOutput("aRdata", 32'(aRdata), 32'(pendAData));
      if (pendB) checkOutput("bRdata", 32'(bRdata), 32'(pendBData));
`ifdef ARB_WAIT_CNT_EN
      checkOutput("aWaitCnt", 32'(aWaitCnt), 32'(waitA));
      checkOutput("bWaitCnt", 32'(bWaitCnt), 32'(waitB));
      if (aReq && (expAGnt == 0) && (waitA != 16'hFFFF)) waitA = waitA + 16'd1;
      if (bReq && (expBGnt == 0) && (waitB != 16'hFFFF)) waitB = waitB + 16'd1;
`endif
      pendA     = (expAGnt != 0) && !aWe;
      pendB     = (expBGnt != 0) && !bWe;
      pendAData = modelMem[aAddr[5:0]];
      pendBData = modelMem[bAddr[5:0]];
      if ((expAGnt != 0) && aWe) modelMem[aAddr[5:0]] = aWdata;
      if ((expBGnt != 0) && bWe) modelMem[bAddr[5:0]] = bWdata;
      if (owner == 0) begin
        streak = 0;
        if (aReq && bReq) owner = lastB ? 1 : 2;
        else if (aReq) owner = 1;
        else if (bReq) owner = 2;
      end else if (owner == 1) begin
        if (!aReq) begin
          lastB  = 1'b0;
          streak = 0;
          owner  = bReq ? 2 : 0;
        end else if (bReq) begin
          streak++;
          if (streak >= MAX_HOLD && !aLock) begin
            lastB  = 1'b0;
            streak = 0;
            owner  = 2;
          end
        end else begin
          streak = 0;
        end
      end else begin
        if (!bReq) begin
          lastB  = 1'b1;
          streak = 0;
          owner  = aReq ? 1 : 0;
        end else if (aReq) begin
          streak++;
          if (streak >= MAX_HOLD && !bLock) begin
            lastB  = 1'b1;
            streak = 0;
            owner  = 1;
          end
        end else begin
          streak = 0;
        end
      end
    end
  end

  // Drives one cycle of requester inputs, 1 time unit after the rising edge.
  task automatic applyStimulus(input logic ar, input logic al, input logic aw,
                               input logic [23:0] aa, input logic [15:0] ad,
                               input logic br, input logic bl, input logic bw,
                               input logic [23:0] ba, input logic [15:0] bd);
    @(posedge clk);
    #1;
    aReq = ar; aLock = al; aWe = aw; aAddr = aa; aWdata = ad;
    bReq = br; bLock = bl; bWe = bw; bAddr = ba; bWdata = bd;
  endtask

  task automatic idleCycle();
    applyStimulus(0, 0, 0, 24'h0, 16'h0, 0, 0, 0, 24'h0, 16'h0);
  endtask

  // One-cycle reset pulse. Both edges sit 3 units after a rising edge.
  task automatic resetPulse();
    @(posedge clk);
    #1;
    aReq = 0; aLock = 0; aWe = 0; aAddr = '0; aWdata = '0;
    bReq = 0; bLock = 0; bWe = 0; bAddr = '0; bWdata = '0;
    #2 rst_n = 1'b0;
    @(posedge clk);
    #3 rst_n = 1'b1;
  endtask

  // Directed scenarios with literal expectations, then random traffic.
  initial begin : stimulus
    int aCnt;
    int bCnt;
    int firstB;
    logic seen;
    aReq = 0; aLock = 0; aWe = 0; aAddr = '0; aWdata = '0;
    bReq = 0; bLock = 0; bWe = 0; bAddr = '0; bWdata = '0;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #1;
    checkOutput("inRstAGnt", 32'(aGnt), 32'd0);
    checkOutput("inRstMemAddr", 32'(memAddr), 32'd0);
    checkOutput("inRstMemWe", 32'(memWe), 32'd0);
    checkOutput("inRstARvalid", 32'(aRvalid), 32'd0);
    @(posedge clk);
    @(posedge clk);
    #3 rst_n = 1'b1;
    #1;
    checkOutput("postRstBGnt", 32'(bGnt), 32'd0);
    checkOutput("postRstMemWdata", 32'(memWdata), 32'd0);

    // A alone from IDLE: no grant on the first cycle, a grant on the next,
    // and the data arrives one cycle later.
    applyStimulus(1, 0, 0, 24'h000010, 16'h0, 0, 0, 0, 24'h0, 16'h0);
    #1 checkOutput("s1FirstAGnt", 32'(aGnt), 32'd0);
    applyStimulus(1, 0, 0, 24'h000010, 16'h0, 0, 0, 0, 24'h0, 16'h0);
    #1 checkOutput("s1SecondAGnt", 32'(aGnt), 32'd1);
    checkOutput("s1MemAddr", 32'(memAddr), 32'h000010);
    idleCycle();
    #1 checkOutput("s1ARvalid", 32'(aRvalid), 32'd1);
    checkOutput("s1ARdata", 32'(aRdata), 32'h1010);

    // A tie out of reset goes to A. A releases after three accesses and
    // B takes over. A later tie from IDLE goes to A again.
    resetPulse();
    applyStimulus(1, 0, 0, 24'h000020, 16'h0, 1, 0, 0, 24'h000030, 16'h0);
    #1 checkOutput("s2TieIdleAGnt", 32'(aGnt), 32'd0);
    checkOutput("s2TieIdleBGnt", 32'(bGnt), 32'd0);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1, 0, 0, 24'h000020, 16'h0, 1, 0, 0, 24'h000030, 16'h0);
      #1 checkOutput("s2AOwnsAGnt", 32'(aGnt), 32'd1);
      checkOutput("s2AOwnsBGnt", 32'(bGnt), 32'd0);
    end
    applyStimulus(0, 0, 0, 24'h0, 16'h0, 1, 0, 0, 24'h000030, 16'h0);
    #1 checkOutput("s2ReleaseBGnt", 32'(bGnt), 32'd0);
    applyStimulus(0, 0, 0, 24'h0, 16'h0, 1, 0, 0, 24'h000030, 16'h0);
    #1 checkOutput("s2HandoffBGnt", 32'(bGnt), 32'd1);
    idleCycle();
    applyStimulus(1, 0, 0, 24'h000020, 16'h0, 1, 0, 0, 24'h000030, 16'h0);
    applyStimulus(1, 0, 0, 24'h000020, 16'h0, 1, 0, 0, 24'h000030, 16'h0);
    #1 checkOutput("s2SecondTieAGnt", 32'(aGnt), 32'd1);
    checkOutput("s2SecondTieBGnt", 32'(bGnt), 32'd0);

    // Bounded hold: A streams unlocked while B waits. Exactly MAX_HOLD
    // grants go to A, then B gets the next cycle.
    resetPulse();
`ifdef ARB_WAIT_CNT_EN
    #1 checkOutput("s3BWaitAfterRst", 32'(bWaitCnt), 32'd0);
`endif
    applyStimulus(1, 0, 0, 24'h000001, 16'h0, 0, 0, 0, 24'h0, 16'h0);
    aCnt = 0;
    firstB = -1;
    for (int i = 0; i < 12; i++) begin
      applyStimulus(1, 0, 0, 24'h000001, 16'h0, 1, 0, 0, 24'h000002, 16'h0);
      #1;
      if (bGnt && firstB < 0) begin
        firstB = i;
`ifdef ARB_WAIT_CNT_EN
        checkOutput("s3BWaitCnt", 32'(bWaitCnt), 32'd8);
`endif
      end
      if (aGnt && firstB < 0) aCnt++;
    end
    checkOutput("s3AGrantCount", 32'(aCnt), 32'd8);
    checkOutput("s3FirstBCycle", 32'(firstB), 32'd8);
    idleCycle();

    // Lock: A keeps the port through 24 cycles of B waiting. When the lock
    // drops at hold saturation, B is granted on the following cycle.
    applyStimulus(1, 0, 0, 24'h000003, 16'h0, 0, 0, 0, 24'h0, 16'h0);
    aCnt = 0;
    bCnt = 0;
    for (int i = 0; i < 24; i++) begin
      applyStimulus(1, 1, 0, 24'h000003, 16'h0, 1, 0, 0, 24'h000005, 16'h0);
      #1;
      if (aGnt) aCnt++;
      if (bGnt) bCnt++;
    end
    checkOutput("s4LockedAGrants", 32'(aCnt), 32'd24);
    checkOutput("s4LockedBGrants", 32'(bCnt), 32'd0);
    applyStimulus(1, 0, 0, 24'h000003, 16'h0, 1, 0, 0, 24'h000005, 16'h0);
    #1 checkOutput("s4UnlockAGnt", 32'(aGnt), 32'd1);
    applyStimulus(1, 0, 0, 24'h000003, 16'h0, 1, 0, 0, 24'h000005, 16'h0);
    #1 checkOutput("s4AfterUnlockBGnt", 32'(bGnt), 32'd1);
    checkOutput("s4AfterUnlockAGnt", 32'(aGnt), 32'd0);
    idleCycle();

    // A read on A's last owned cycle returns to A during B's first write.
    applyStimulus(1, 0, 0, 24'h000008, 16'h0, 0, 0, 0, 24'h0, 16'h0);
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      applyStimulus(1, 0, 0, 24'h000008, 16'h0, 1, 0, 1, 24'h010004, 16'hBEEF);
      #1;
      if (bGnt) begin
        seen = 1'b1;
        checkOutput("s5ARvalid", 32'(aRvalid), 32'd1);
        checkOutput("s5ARdata", 32'(aRdata), 32'h1008);
        checkOutput("s5MemWe", 32'(memWe), 32'd1);
        checkOutput("s5MemAddr", 32'(memAddr), 32'h010004);
        checkOutput("s5MemWdata", 32'(memWdata), 32'hBEEF);
        checkOutput("s5BRvalid", 32'(bRvalid), 32'd0);
      end
    end
    checkOutput("s5BGrantSeen", 32'(seen), 32'd1);
    applyStimulus(0, 0, 0, 24'h0, 16'h0, 1, 0, 0, 24'h010004, 16'h0);
    #1 checkOutput("s5BReadGnt", 32'(bGnt), 32'd1);
    idleCycle();
    #1 checkOutput("s5BReadRvalid", 32'(bRvalid), 32'd1);
    checkOutput("s5BReadData", 32'(bRdata), 32'hBEEF);

    // Reset mid-read drops grant and rvalid at once and discards the read.
    applyStimulus(1, 0, 0, 24'h000010, 16'h0, 0, 0, 0, 24'h0, 16'h0);
    applyStimulus(1, 0, 0, 24'h000010, 16'h0, 0, 0, 0, 24'h0, 16'h0);
    #1 checkOutput("s6PreRstAGnt", 32'(aGnt), 32'd1);
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1 checkOutput("s6RstARvalid", 32'(aRvalid), 32'd0);
    checkOutput("s6RstAGnt", 32'(aGnt), 32'd0);
    checkOutput("s6RstBGnt", 32'(bGnt), 32'd0);
    checkOutput("s6RstMemAddr", 32'(memAddr), 32'd0);
    @(posedge clk);
    #3 rst_n = 1'b1;
    #1 checkOutput("s6IdleAGnt", 32'(aGnt), 32'd0);
    idleCycle();
    #1 checkOutput("s6NoLateRvalid", 32'(aRvalid), 32'd0);

    // Random traffic with occasional reset pulses.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 999) < 3) begin
        resetPulse();
      end else begin
        applyStimulus($urandom_range(0, 3) != 0, $urandom_range(0, 7) == 0,
                      1'($urandom_range(0, 1)), 24'($urandom),
                      16'($urandom),
                      $urandom_range(0, 3) != 0, $urandom_range(0, 7) == 0,
                      1'($urandom_range(0, 1)), 24'($urandom),
                      16'($urandom));
      end
    end
    idleCycle();
    idleCycle();
    @(posedge clk);
    #2;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
